// File: rtl/alu_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, then a sign-fix
// cycle and a one-cycle done pulse. Results hold until the next completion.
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             o,
  output logic             z,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] orig;
  logic             q_neg, r_neg, ovf, dz_p;

  logic             accept;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    accept  = start && ((state == IDLE) || (state == DONE));
    dvd_neg = signed_op & dividend[WIDTH-1];
    dvs_neg = signed_op & divisor[WIDTH-1];
    shifted = {prem[WIDTH-1:0], acc[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    q_fix   = q_neg ? (~acc + 1'b1) : acc;
    r_fix   = r_neg ? (~prem[WIDTH-1:0] + 1'b1) : prem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      dvs       <= '0;
      prem      <= '0;
      orig      <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      ovf       <= 1'b0;
      dz_p      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      o         <= 1'b0;
      z         <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // Magnitudes feed the unsigned core; signs are reapplied in FIX.
            acc   <= dvd_neg ? (~dividend + 1'b1) : dividend;
            dvs   <= dvs_neg ? (~divisor + 1'b1) : divisor;
            orig  <= dividend;
            prem  <= '0;
            cnt   <= CW'(WIDTH - 1);
            q_neg <= dvd_neg ^ dvs_neg;
            r_neg <= dvd_neg;
            ovf   <= signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
            dz_p  <= (divisor == '0);
            busy  <= 1'b1;
            state <= (divisor == '0) ? FIX : RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (trial[WIDTH]) begin
            prem <= shifted;
            acc  <= {acc[WIDTH-2:0], 1'b0};
          end else begin
            prem <= trial;
            acc  <= {acc[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (dz_p) begin
            quotient  <= '1;
            remainder <= orig;
            o         <= 1'b0;
            z         <= 1'b0;
            dz        <= 1'b1;
          end else begin
            // MIN / -1 already yields MIN with zero remainder from the magnitudes.
            quotient  <= q_fix;
            remainder <= r_fix;
            o         <= ovf;
            z         <= (q_fix == '0);
            dz        <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Randomized and directed bench for alu_divider against an integer-arithmetic model.
module tb_alu_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, signed_op;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, o, z, dz;

  int checks   = 0;
  int failures = 0;

  alu_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .o(o), .z(z), .dz(dz)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, which truncates toward zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic eo, output logic ez, output logic edz);
    int ia, ib;
    eo = 1'b0; edz = 1'b0;
    if (b == 0) begin
      q = '1; r = a; edz = 1'b1;
    end else if (s) begin
      ia = $signed(a); ib = $signed(b);
      if (ia == -(1 << (W-1)) && ib == -1) begin
        q = a; r = '0; eo = 1'b1;
      end else begin
        q = W'(ia / ib); r = W'(ia % ib);
      end
    end else begin
      q = a / b; r = a % b;
    end
    ez = (edz == 1'b0) && (q == 0);
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles from the one after the accepting edge until done.
  task automatic wait_done(output int lat, output int bn);
    lat = 1; bn = 0;
    while (!done && lat < 40) begin
      if (busy) bn++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({quotient, remainder, busy, done, o, z, dz} !== '0) begin
      failures++;
      $display("FAIL reset: q=%h r=%h busy=%b done=%b o=%b z=%b dz=%b, want all 0",
               quotient, remainder, busy, done, o, z, dz);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [10] = '{8'h64, 8'h9C, 8'h64, 8'h55, 8'h80, 8'h03, 8'h80, 8'h55, 8'h80, 8'hFF};
    logic [W-1:0] tb [10] = '{8'h07, 8'h07, 8'hF9, 8'h00, 8'hFF, 8'h07, 8'hFF, 8'h00, 8'h01, 8'hFF};
    logic         ts [10] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [W-1:0] eq, er;
    logic eo, ez, edz;
    int lat, bn;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch(ta[i], tb[i], ts[i]);
      wait_done(lat, bn);
      model(ta[i], tb[i], ts[i], eq, er, eo, ez, edz);
      checks++;
      if ({quotient, remainder, o, z, dz} !== {eq, er, eo, ez, edz}) begin
        failures++;
        $display("FAIL directed[%0d] %h/%h s=%b: got q=%h r=%h o=%b z=%b dz=%b, want q=%h r=%h o=%b z=%b dz=%b",
                 i, ta[i], tb[i], ts[i], quotient, remainder, o, z, dz, eq, er, eo, ez, edz);
      end
      checks++;
      if (lat != ((tb[i] == 0) ? 2 : W + 2) || bn != ((tb[i] == 0) ? 1 : W + 1)) begin
        failures++;
        $display("FAIL directed_timing[%0d]: got latency=%0d busy_cycles=%0d, want %0d/%0d",
                 i, lat, bn, (tb[i] == 0) ? 2 : W + 2, (tb[i] == 0) ? 1 : W + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [3] = '{8'h64, 8'h55, 8'h9C};
    logic [W-1:0] tb [3] = '{8'h07, 8'h00, 8'h07};
    logic         ts [3] = '{1'b0,  1'b0,  1'b1};
    logic [W-1:0] eq, er;
    logic eo, ez, edz;
    int lat, bn;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      // Launch straight from the DONE cycle of the previous op.
      launch(ta[i], tb[i], ts[i]);
      wait_done(lat, bn);
      model(ta[i], tb[i], ts[i], eq, er, eo, ez, edz);
      checks++;
      if (lat != ((tb[i] == 0) ? 2 : W + 2) ||
          {quotient, remainder, o, z, dz} !== {eq, er, eo, ez, edz}) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got lat=%0d q=%h r=%h o=%b z=%b dz=%b, want lat=%0d q=%h r=%h o=%b z=%b dz=%b",
                 i, lat, quotient, remainder, o, z, dz, (tb[i] == 0) ? 2 : W + 2, eq, er, eo, ez, edz);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] eq, er;
    logic eo, ez, edz;
    int lat, extra;
    @(negedge clk);
    launch(8'h64, 8'h07, 1'b0);
    @(negedge clk);
    dividend = 8'hC8; divisor = 8'h0A; signed_op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 8'h11; divisor = 8'h00;
    lat = 3;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    model(8'h64, 8'h07, 1'b0, eq, er, eo, ez, edz);
    checks++;
    if (lat != W + 2 || {quotient, remainder, o, z, dz} !== {eq, er, eo, ez, edz}) begin
      failures++;
      $display("FAIL ignore_start: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h",
               lat, quotient, remainder, W + 2, eq, er);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || quotient !== eq || remainder !== er) begin
      failures++;
      $display("FAIL ignore_start_extra: got extra_done=%0d q=%h r=%h, want 0 and held q=%h r=%h",
               extra, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic s, eo, ez, edz;
    int lat, bn;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin a = 8'h80; b = 8'hFF; end
      @(negedge clk);
      launch(a, b, s);
      wait_done(lat, bn);
      model(a, b, s, eq, er, eo, ez, edz);
      checks++;
      if (lat != ((b == 0) ? 2 : W + 2) ||
          {quotient, remainder, o, z, dz} !== {eq, er, eo, ez, edz}) begin
        failures++;
        $display("FAIL random[%0d] %h/%h s=%b: got lat=%0d q=%h r=%h o=%b z=%b dz=%b, want lat=%0d q=%h r=%h o=%b z=%b dz=%b",
                 i, a, b, s, lat, quotient, remainder, o, z, dz, (b == 0) ? 2 : W + 2, eq, er, eo, ez, edz);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] eq, er;
    logic eo, ez, edz;
    int lat, bn, extra;
    @(negedge clk);
    launch(8'h9C, 8'h07, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({quotient, remainder, busy, done, o, z, dz} !== '0) begin
      failures++;
      $display("FAIL reset_mid: q=%h r=%h busy=%b done=%b o=%b z=%b dz=%b, want all 0",
               quotient, remainder, busy, done, o, z, dz);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: got %0d cycles with done/busy, want 0", extra);
    end
    launch(8'hC8, 8'h0A, 1'b0);
    wait_done(lat, bn);
    model(8'hC8, 8'h0A, 1'b0, eq, er, eo, ez, edz);
    checks++;
    if (lat != W + 2 || {quotient, remainder, o, z, dz} !== {eq, er, eo, ez, edz}) begin
      failures++;
      $display("FAIL reset_mid_fresh: got lat=%0d q=%h r=%h, want lat=%0d q=%h r=%h",
               lat, quotient, remainder, W + 2, eq, er);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_divider.md
Name: alu_divider

Overview:
- Multi-cycle restoring integer divider for the execute stage. It is the inverse counterpart of the ALU's add/sub/multiply datapath.
- Accepts a dividend and divisor on a start strobe and iterates one quotient bit per clock.
- Returns quotient, remainder and o/z/divide-by-zero flags with a one-cycle done pulse.
- Pipeline control stalls on busy.

Parameters:
- WIDTH, 8: operand, quotient and remainder width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when the block can accept
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned
- dividend  input  WIDTH  numerator; captured on accepted start
- divisor  input  WIDTH  denominator; captured on accepted start
- quotient  output  WIDTH  result quotient; valid when done=1, held afterwards
- remainder  output  WIDTH  result remainder; valid when done=1, held afterwards
- busy  output  1  high while an operation is in flight (states RUN, FIX)
- done  output  1  one-cycle pulse, results valid
- o  output  1  signed overflow (most-negative / -1)
- z  output  1  quotient == 0
- dz  output  1  divide by zero

Behaviour:
- Reset (rst=1 at a clock edge):
  - State is IDLE.
  - quotient=0, remainder=0, busy=0, done=0, o=0, z=0, dz=0.
  - Iteration counter=0.
  - Reset overrides every state, including mid-operation. Any in-flight result is discarded and no done pulse follows.
- States:
  - IDLE: waiting.
  - RUN: WIDTH iterations.
  - FIX: sign correction and flag computation.
  - DONE: done=1 for exactly one cycle.
- Accept:
  - start=1 is accepted only in IDLE or DONE. Back-to-back operation is allowed; start in DONE does not suppress that cycle's done pulse.
  - start in RUN or FIX is ignored, with no queueing.
  - On accept, latch dividend, divisor and signed_op.
- Operand preparation at accept:
  - If signed_op=1, convert the operands to magnitudes.
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - If signed_op=0, both sign flags are 0.
- Divide-by-zero (latched divisor == 0):
  - Go IDLE/DONE -> FIX directly, skipping RUN.
  - FIX loads quotient = all ones, remainder = the original latched dividend (unmodified), dz=1, o=0, z=0.
  - done asserts 2 cycles after the accepting edge.
- RUN, one step per clock, counter from WIDTH-1 down to 0:
  - Partial remainder P (WIDTH+1 bits) = {P, next dividend bit}.
  - Trial subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore P and set the bit to 0.
  - After WIDTH cycles go to FIX.
- FIX:
  - Negate the quotient if q_neg; negate the remainder if r_neg. Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed most-negative / -1 (e.g. 0x80 / 0xFF at WIDTH=8): quotient = most-negative value, remainder=0, o=1.
  - z = (final quotient == 0). dz=0 for all non-zero divisors.
- Latency:
  - Normal divide: done asserts WIDTH+2 cycles after the accepting edge, i.e. 10 cycles at WIDTH=8 (WIDTH RUN + FIX + DONE).
  - busy is high from the cycle after accept through the FIX cycle, and low in DONE and IDLE.
- Output timing:
  - quotient, remainder, o, z and dz update only on the FIX->DONE transition.
  - They hold their values through IDLE and any following RUN until the next done.
- DONE -> IDLE if no start; DONE -> RUN (or FIX for a zero divisor) on start.
- Unsigned divides never set o.
- Input changes while busy have no effect.

Test Plan:
- Unsigned: 100 / 7 (0x64/0x07), signed_op=0 -> quotient=0x0E, remainder=0x02, z=0, o=0, dz=0; done exactly 10 cycles after the accepting edge; busy high for 9 cycles.
- Signed: -100 / 7 (0x9C/0x07), signed_op=1 -> quotient=0xF2 (-14), remainder=0xFE (-2).
- Signed: 100 / -7 (0x64/0xF9), signed_op=1 -> quotient=0xF2, remainder=0x02.
- Zero and overflow corners:
  - 0x55 / 0x00 -> quotient=0xFF, remainder=0x55, dz=1; done 2 cycles after accept.
  - 0x80 / 0xFF signed -> quotient=0x80, remainder=0x00, o=1.
  - 0x03 / 0x07 unsigned -> quotient=0, remainder=0x03, z=1.
- Handshake:
  - A second start pulsed during RUN is ignored: exactly one done, with the first operands' results.
  - start held high in the DONE cycle launches the next op: second done exactly 10 cycles later.
- Reset mid-operation: assert rst in the 4th RUN cycle -> next cycle all outputs 0, state IDLE, and no done within 20 cycles. A fresh start then completes normally (200/10 -> quotient=0x14, remainder=0).
